// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: FSM encodings, requester IDs,
// reset/stall polarities and the byte-count decode.
package mem_ctrl_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic Src_IF  = 1'b0;
    localparam logic Src_MEM = 1'b1;

    localparam logic ResetEnable = 1'b1;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

    // Only 1 and 2 are honoured; every other encoding means a full word.
    function automatic logic [2:0] decode_len(input logic [2:0] l);
        case (l)
            3'd1, 3'd2: return l;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer sharing one 8-bit RAM port between fetch (IF) and load/store (MEM).
// MEM wins arbitration; a granted transaction runs to completion unless a flush aborts a fetch.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    logic [1:0]        state_q, state_d;
    logic              src_q, src_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        ic_q, ic_d;
    logic [2:0]        cc_q, cc_d;
    logic              first_q, first_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    // ram_a is registered, so byte 0 is issued on acceptance and ic counts issued bytes.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        len_d       = len_q;
        ic_d        = ic_q;
        cc_d        = cc_q;
        first_d     = first_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    src_d   = Src_MEM;
                    len_d   = decode_len(mem_len);
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    ram_a_d = mem_addr;
                    ic_d    = 3'd1;
                    cc_d    = 3'd0;
                    first_d = 1'b1;
                    asm_d   = 32'd0;
                    if (mem_we) begin
                        ram_dout_d = mem_wdata[7:0];
                        ram_wr_d   = 1'b1;
                        state_d    = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end else if (if_req && !flush) begin
                    src_d   = Src_IF;
                    len_d   = 3'd4;
                    addr_d  = if_addr;
                    ram_a_d = if_addr;
                    ic_d    = 3'd1;
                    cc_d    = 3'd0;
                    first_d = 1'b1;
                    asm_d   = 32'd0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (flush && src_q == Src_IF) begin
                    state_d = StIdle;
                end else begin
                    first_d = 1'b0;
                    if (ic_q < len_q) begin
                        ram_a_d = addr_q + ADDR_W'(ic_q);
                        ic_d    = ic_q + 3'd1;
                    end
                    // RAM data lags the address by one cycle; nothing to capture yet on entry.
                    if (!first_q) begin
                        asm_d[{cc_q[1:0], 3'b000} +: 8] = ram_din;
                        cc_d = cc_q + 3'd1;
                        if (cc_q + 3'd1 == len_q) begin
                            state_d = StDone;
                            if (src_q == Src_IF) begin
                                if_data_d = asm_d;
                            end else begin
                                mem_rdata_d = asm_d;
                            end
                        end
                    end
                end
            end
            StWrite: begin
                if (ic_q < len_q) begin
                    ram_a_d    = addr_q + ADDR_W'(ic_q);
                    ram_dout_d = wdata_q[{ic_q[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                    ic_d       = ic_q + 3'd1;
                end else begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            state_q     <= StIdle;
            src_q       <= Src_IF;
            len_q       <= 3'd0;
            ic_q        <= 3'd0;
            cc_q        <= 3'd0;
            first_q     <= 1'b0;
            asm_q       <= 32'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            len_q       <= len_d;
            ic_q        <= ic_d;
            cc_q        <= cc_d;
            first_q     <= first_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        if_done           = (state_q == StDone) && (src_q == Src_IF);
        mem_done          = (state_q == StDone) && (src_q == Src_MEM);
        if_data           = if_data_q;
        mem_rdata         = mem_rdata_q;
        ram_a             = ram_a_q;
        ram_dout          = ram_dout_q;
        ram_wr            = ram_wr_q;
        stallreq_from_if  = (if_req && !if_done) ? Stop : NoStop;
        stallreq_from_mem = (mem_req && !mem_done) ? Stop : NoStop;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model, reference byte store updated from
// the intended transactions, and per-cycle logs compared against the documented timing.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        stallreq_from_if;
    logic        stallreq_from_mem;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int checks;
    int failures;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_done           (if_done),
        .if_data           (if_data),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_len           (mem_len),
        .mem_wdata         (mem_wdata),
        .mem_done          (mem_done),
        .mem_rdata         (mem_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout),
        .ram_a             (ram_a),
        .ram_wr            (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram_store [logic [31:0]];
    logic [7:0] ref_mem   [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function logic [7:0] store_byte(input logic [31:0] a);
        return ram_store.exists(a) ? ram_store[a] : dflt(a);
    endfunction

    function logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function logic [31:0] ref_word(input logic [31:0] a, input int len);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < len; i++) w[8*i +: 8] = ref_byte(a + 32'(i));
        return w;
    endfunction

    // RAM: one-cycle read latency on the address presented in the previous cycle.
    always @(posedge clk) begin
        if (ram_wr === 1'b1) ram_store[ram_a] = ram_dout;
        ram_din <= store_byte(ram_a);
    end

    // Scenario configuration and per-cycle observation log
    int          t_if_start, t_mem_start;
    logic [31:0] t_if_addr, t_mem_addr, t_mem_wdata;
    logic        t_mem_we;
    logic [2:0]  t_mem_len;
    logic        lg_wr   [0:39];
    logic [31:0] lg_a    [0:39];
    logic [7:0]  lg_dout [0:39];
    logic        lg_sif  [0:39];
    logic        lg_smem [0:39];
    logic [31:0] lg_ir   [0:39];
    logic [31:0] lg_mr   [0:39];
    int          if_done_cyc, mem_done_cyc, if_done_cnt, mem_done_cnt;
    logic [31:0] if_got, mem_got;

    task automatic clear_cfg();
        t_if_start  = -1;
        t_mem_start = -1;
        t_if_addr   = 32'd0;
        t_mem_addr  = 32'd0;
        t_mem_wdata = 32'd0;
        t_mem_we    = 1'b0;
        t_mem_len   = 3'd4;
    endtask

    // Requesters hold req until their done pulse; a flush or reset also withdraws them.
    task automatic run_cycles(input int n, input int flush_cyc, input int rst_cyc);
        bit if_pend, mem_pend;
        if_pend = 0; mem_pend = 0;
        if_done_cyc = -1; mem_done_cyc = -1; if_done_cnt = 0; mem_done_cnt = 0;
        if_got = 32'hx; mem_got = 32'hx;
        for (int c = 0; c < n; c++) begin
            if (c == t_if_start) if_pend = 1;
            if (c == t_mem_start) mem_pend = 1;
            if_req    = if_pend;
            if_addr   = t_if_addr;
            mem_req   = mem_pend;
            mem_we    = t_mem_we;
            mem_addr  = t_mem_addr;
            mem_len   = t_mem_len;
            mem_wdata = t_mem_wdata;
            flush     = (c == flush_cyc);
            rst       = (c == rst_cyc);
            #1;
            lg_wr[c] = ram_wr; lg_a[c] = ram_a; lg_dout[c] = ram_dout;
            lg_sif[c] = stallreq_from_if; lg_smem[c] = stallreq_from_mem;
            lg_ir[c] = if_data; lg_mr[c] = mem_rdata;
            if (if_done === 1'b1) begin
                if_done_cnt++; if_done_cyc = c; if_got = if_data; if_pend = 0;
            end
            if (mem_done === 1'b1) begin
                mem_done_cnt++; mem_done_cyc = c; mem_got = mem_rdata; mem_pend = 0;
            end
            if (flush) if_pend = 0;
            if (rst) begin if_pend = 0; mem_pend = 0; end
            @(posedge clk);
            #1;
        end
        if_req = 0; mem_req = 0; flush = 0; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_len = 0; mem_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        checks++;
        if ({ram_a, ram_dout, ram_wr, if_done, mem_done} !== 43'd0) begin
            failures++;
            $display("FAIL reset_ram_done got a=%h d=%h wr=%b ifd=%b memd=%b want all 0",
                     ram_a, ram_dout, ram_wr, if_done, mem_done);
        end
        checks++;
        if ({if_data, mem_rdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got if=%h mem=%h want 0", if_data, mem_rdata);
        end
        checks++;
        if ({stallreq_from_if, stallreq_from_mem} !== 2'b00) begin
            failures++;
            $display("FAIL reset_stall got %b%b want 00", stallreq_from_if, stallreq_from_mem);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        logic [31:0] base;
        base = 32'h100;
        for (int i = 0; i < 4; i++) begin
            ram_store[base + 32'(i)] = 8'h11 * 8'(i + 1);
            ref_mem[base + 32'(i)]   = 8'h11 * 8'(i + 1);
        end
        clear_cfg();
        t_if_start = 0; t_if_addr = base;
        run_cycles(9, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lg_a[1+i] !== base + 32'(i)) begin
                failures++;
                $display("FAIL fetch_addr cyc%0d got %h want %h", 1 + i, lg_a[1+i], base + 32'(i));
            end
        end
        checks++;
        if (if_done_cyc !== 6 || if_done_cnt !== 1) begin
            failures++;
            $display("FAIL fetch_done_cycle got cyc=%0d cnt=%0d want 6/1", if_done_cyc, if_done_cnt);
        end
        checks++;
        if (if_got !== 32'h44332211) begin
            failures++;
            $display("FAIL fetch_data got %h want 44332211", if_got);
        end
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (lg_sif[c] !== (c < 6) || lg_wr[c] !== 1'b0) begin
                failures++;
                $display("FAIL fetch_stall cyc%0d got stall=%b wr=%b want %b/0",
                         c, lg_sif[c], lg_wr[c], c < 6);
            end
        end
    endtask

    task automatic test_store();
        clear_cfg();
        t_mem_start = 0; t_mem_we = 1; t_mem_len = 3'd2;
        t_mem_addr = 32'h200; t_mem_wdata = 32'hAABBCCDD;
        ref_mem[32'h200] = 8'hDD;
        ref_mem[32'h201] = 8'hCC;
        run_cycles(6, -1, -1);
        for (int c = 0; c < 6; c++) begin
            logic        ew;
            logic [31:0] ea;
            logic [7:0]  ed;
            ew = (c == 1 || c == 2);
            ea = 32'h200 + 32'(c - 1);
            ed = (c == 1) ? 8'hDD : 8'hCC;
            checks++;
            if (lg_wr[c] !== ew || (ew && (lg_a[c] !== ea || lg_dout[c] !== ed))) begin
                failures++;
                $display("FAIL store_bus cyc%0d got wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                         c, lg_wr[c], lg_a[c], lg_dout[c], ew, ea, ed);
            end
        end
        checks++;
        if (mem_done_cyc !== 3 || mem_done_cnt !== 1) begin
            failures++;
            $display("FAIL store_done got cyc=%0d cnt=%0d want 3/1", mem_done_cyc, mem_done_cnt);
        end
        checks++;
        if (ram_store[32'h200] !== 8'hDD || ram_store[32'h201] !== 8'hCC) begin
            failures++;
            $display("FAIL store_ram got %h %h want DD CC", ram_store[32'h200], ram_store[32'h201]);
        end
    endtask

    task automatic test_simultaneous();
        clear_cfg();
        t_if_start = 0; t_if_addr = {$urandom_range(0, 65535), 2'b00};
        t_mem_start = 0; t_mem_we = 0; t_mem_len = 3'd1; t_mem_addr = $urandom;
        run_cycles(13, -1, -1);
        checks++;
        if (mem_done_cyc !== 3 || mem_got !== ref_word(t_mem_addr, 1)) begin
            failures++;
            $display("FAIL simul_mem got cyc=%0d data=%h want 3 %h",
                     mem_done_cyc, mem_got, ref_word(t_mem_addr, 1));
        end
        checks++;
        if (if_done_cyc !== 10 || if_got !== ref_word(t_if_addr, 4)) begin
            failures++;
            $display("FAIL simul_if got cyc=%0d data=%h want 10 %h",
                     if_done_cyc, if_got, ref_word(t_if_addr, 4));
        end
        checks++;
        if (lg_a[5] !== t_if_addr || lg_a[8] !== t_if_addr + 32'd3) begin
            failures++;
            $display("FAIL simul_if_addr got %h..%h want %h..%h",
                     lg_a[5], lg_a[8], t_if_addr, t_if_addr + 32'd3);
        end
    endtask

    task automatic test_flush();
        clear_cfg();
        t_if_start = 0; t_if_addr = 32'h0000_0400;
        t_mem_start = 2; t_mem_we = 0; t_mem_len = 3'd4; t_mem_addr = 32'h0000_0800;
        run_cycles(13, 3, -1);
        checks++;
        if (if_done_cnt !== 0) begin
            failures++;
            $display("FAIL flush_no_ifdone got %0d pulses want 0", if_done_cnt);
        end
        checks++;
        if (lg_a[5] !== 32'h800 || mem_done_cyc !== 10) begin
            failures++;
            $display("FAIL flush_mem_accept got a5=%h done=%0d want 800 10", lg_a[5], mem_done_cyc);
        end
        checks++;
        if (mem_got !== ref_word(32'h800, 4)) begin
            failures++;
            $display("FAIL flush_mem_data got %h want %h", mem_got, ref_word(32'h800, 4));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF;
        exp_a[2] = 32'h00000000; exp_a[3] = 32'h00000001;
        clear_cfg();
        t_mem_start = 0; t_mem_we = 0; t_mem_len = 3'd4; t_mem_addr = 32'hFFFFFFFE;
        run_cycles(8, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lg_a[1+i] !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_addr cyc%0d got %h want %h", 1 + i, lg_a[1+i], exp_a[i]);
            end
        end
        checks++;
        if (mem_got !== ref_word(32'hFFFFFFFE, 4)) begin
            failures++;
            $display("FAIL wrap_data got %h want %h", mem_got, ref_word(32'hFFFFFFFE, 4));
        end
    endtask

    task automatic test_reset_mid();
        clear_cfg();
        t_mem_start = 0; t_mem_we = 1; t_mem_len = 3'd4;
        t_mem_addr = 32'h300; t_mem_wdata = 32'h87654321;
        // Bytes 0 and 1 reach the RAM before the reset takes effect.
        ref_mem[32'h300] = 8'h21;
        ref_mem[32'h301] = 8'h43;
        run_cycles(6, -1, 2);
        checks++;
        if (lg_wr[1] !== 1'b1 || lg_wr[2] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got wr1=%b wr2=%b want 1 1", lg_wr[1], lg_wr[2]);
        end
        checks++;
        if ({lg_wr[3], lg_a[3], lg_dout[3], lg_ir[3], lg_mr[3]} !== 105'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got wr=%b a=%h d=%h if=%h mem=%h want 0",
                     lg_wr[3], lg_a[3], lg_dout[3], lg_ir[3], lg_mr[3]);
        end
        checks++;
        if (mem_done_cnt !== 0 || ram_store.exists(32'h302)) begin
            failures++;
            $display("FAIL rstmid_dropped got done=%0d byte2_written=%0d want 0 0",
                     mem_done_cnt, ram_store.exists(32'h302));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            int          op, elen, dcyc, nwr;
            logic [2:0]  lraw;
            logic [31:0] a, wd;
            op   = $urandom_range(0, 2);
            lraw = 3'($urandom_range(0, 7));
            elen = (op == 0) ? 4 : ((lraw == 3'd1 || lraw == 3'd2) ? int'(lraw) : 4);
            a    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                                : {16'h0, 16'($urandom)};
            wd   = $urandom;
            clear_cfg();
            if (op == 0) begin
                t_if_start = 0; t_if_addr = a;
            end else begin
                t_mem_start = 0; t_mem_we = (op == 2); t_mem_len = lraw;
                t_mem_addr = a; t_mem_wdata = wd;
            end
            run_cycles(elen + 4, -1, -1);
            dcyc = (op == 0) ? if_done_cyc : mem_done_cyc;
            checks++;
            if (dcyc !== ((op == 2) ? elen + 1 : elen + 2)) begin
                failures++;
                $display("FAIL rand%0d_done op=%0d len=%0d got %0d want %0d",
                         k, op, elen, dcyc, (op == 2) ? elen + 1 : elen + 2);
            end
            nwr = 0;
            for (int c = 0; c < elen + 4; c++) if (lg_wr[c] === 1'b1) nwr++;
            for (int i = 0; i < elen; i++) begin
                checks++;
                if (lg_a[1+i] !== a + 32'(i) ||
                    (op == 2 && lg_dout[1+i] !== wd[8*i +: 8])) begin
                    failures++;
                    $display("FAIL rand%0d_byte%0d got a=%h d=%h want a=%h d=%h", k, i,
                             lg_a[1+i], lg_dout[1+i], a + 32'(i), wd[8*i +: 8]);
                end
            end
            if (op == 2) begin
                for (int i = 0; i < elen; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
            end else begin
                checks++;
                if (((op == 0) ? if_got : mem_got) !== ref_word(a, elen)) begin
                    failures++;
                    $display("FAIL rand%0d_data got %h want %h", k,
                             (op == 0) ? if_got : mem_got, ref_word(a, elen));
                end
            end
            checks++;
            if (nwr !== ((op == 2) ? elen : 0)) begin
                failures++;
                $display("FAIL rand%0d_wrcount got %0d want %0d", k, nwr, (op == 2) ? elen : 0);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
